// File: rtl/cond_logic_mc.sv
`default_nettype none
// ============================================================================
//  Module   : cond_logic_mc
//  Purpose  : Conditional-execution unit of the multicycle ARM core.
//             Holds the architectural NZCV flags, evaluates the instruction
//             condition field against them, latches the pass/fail result for
//             the rest of the instruction and gates the controller's PC,
//             register-file and memory write strobes with it.
//  Ports    : clk        - system clock, all state on rising edge
//             reset      - asynchronous active-low reset
//             Cond       - instruction condition field Instr[31:28]
//             ALUFlags   - {N,Z,C,V} from the ALU
//             FlagW      - [1] write N,Z ; [0] write C,V
//             CondLatch  - capture CondEx into the held condition result
//             PCS        - instruction writes the PC
//             NextPC     - unconditional PC increment strobe
//             RegW       - register-file write request
//             MemW       - data-memory write request
//             NoWrite    - suppress register write (compare/test ops)
//             PCWrite    - gated PC write enable
//             RegWrite   - gated register-file write enable
//             MemWrite   - gated memory write enable
//             Flags      - registered {N,Z,C,V}
//             CondEx     - combinational condition result on Flags/Cond
//  Revision : 1.0 - initial release
// ============================================================================
module cond_logic_mc (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       CondLatch,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    logic [3:0] r_flags;
    logic       r_cond_ex;
    logic [1:0] w_flag_write;
    logic       w_cond_ex;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Condition is always evaluated on the registered flags, so a flag
    // update and a condition latch on the same edge see pre-update flags.
    always_comb begin
        w_cond_ex = 1'b1;
        unique case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = ~(w_n ^ w_v);
            4'b1011: w_cond_ex = w_n ^ w_v;
            4'b1100: w_cond_ex = ~w_z & ~(w_n ^ w_v);
            4'b1101: w_cond_ex = w_z | (w_n ^ w_v);
            default: w_cond_ex = 1'b1;  // AL and the 1111 encoding
        endcase
    end

    // A failed condition blocks both flag halves.
    assign w_flag_write = FlagW & {2{r_cond_ex}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cond_ex <= 1'b0;
        end else if (CondLatch) begin
            r_cond_ex <= w_cond_ex;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags[3:2] <= 2'b00;
        end else if (w_flag_write[1]) begin
            r_flags[3:2] <= ALUFlags[3:2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags[1:0] <= 2'b00;
        end else if (w_flag_write[0]) begin
            r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign PCWrite  = NextPC | (PCS & r_cond_ex);
    assign RegWrite = RegW & ~NoWrite & r_cond_ex;
    assign MemWrite = MemW & r_cond_ex;
    assign Flags    = r_flags;
    assign CondEx   = w_cond_ex;

endmodule
`default_nettype wire
